// File: rtl/stack_cpu.sv
// Stack-machine execution core: program load, then one instruction per clock until HALT or fault.
// Optional single-cycle multiply (opcode 12) enabled by defining STACK_CPU_MUL_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start; program memory writable
// RUN   | executing one instruction per clock
// DONE  | HALT retired, result captured
// ERR   | fault detected, err_code holds cause
module stack_cpu #(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 16,
   parameter int VAR_AW      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [PC_W+3:0]   prog_data,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [DATA_W-1:0] result,
   output logic [15:0]       icount
);

   localparam int SPW = $clog2(STACK_DEPTH);
   localparam logic [SPW:0] SP_ONE  = (SPW+1)'(1);
   localparam logic [SPW:0] SP_TWO  = (SPW+1)'(2);
   localparam logic [SPW:0] SP_FULL = (SPW+1)'(STACK_DEPTH);
   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [SPW:0]      sp, sp_nxt;

   logic [PC_W+3:0]   imem  [2**PC_W];
   logic [DATA_W-1:0] stack [STACK_DEPTH];
   logic [DATA_W-1:0] vmem  [2**VAR_AW];

   logic [PC_W+3:0]   instr;
   logic [3:0]        op;
   logic [PC_W-1:0]   k;
   logic [DATA_W-1:0] a, b, k_data, wr_val;
   logic [SPW-1:0]    wr_idx;
   logic              stack_we, var_we, halt, fault, taken;
   logic [1:0]        fault_code;

   assign instr  = imem[pc];
   assign op     = instr[3:0];
   assign k      = instr[PC_W+3:4];
   assign k_data = DATA_W'(k);
   assign b      = stack[SPW'(sp - SP_ONE)];
   assign a      = stack[SPW'(sp - SP_TWO)];

   assign busy  = (state == S_RUN);
   assign done  = (state == S_DONE);
   assign error = (state == S_ERR);

   always_comb begin
      taken = 1'b0;
      case (op)
         4'd7:    taken = (a == b);
         4'd8:    taken = (a != b);
         4'd9:    taken = (a <= b);
         4'd10:   taken = (a > b);
         default: taken = 1'b0;
      endcase
   end

   // Decode/execute; every fault path leaves writes and sp untouched.
   always_comb begin
      pc_nxt     = pc + PC_ONE;
      sp_nxt     = sp;
      wr_idx     = sp[SPW-1:0];
      wr_val     = '0;
      stack_we   = 1'b0;
      var_we     = 1'b0;
      halt       = 1'b0;
      fault      = 1'b0;
      fault_code = 2'd0;
      case (op)
         4'd0, 4'd1: begin
            if (sp == SP_FULL) begin
               fault      = 1'b1;
               fault_code = 2'd1;
            end else begin
               stack_we = 1'b1;
               wr_val   = (op == 4'd0) ? k_data : vmem[k[VAR_AW-1:0]];
               sp_nxt   = sp + SP_ONE;
            end
         end
         4'd2: begin
            if (sp < SP_ONE) begin
               fault      = 1'b1;
               fault_code = 2'd2;
            end else begin
               var_we = 1'b1;
               sp_nxt = sp - SP_ONE;
            end
         end
`ifdef STACK_CPU_MUL_EN
         4'd3, 4'd4, 4'd12: begin
`else
         4'd3, 4'd4: begin
`endif
            if (sp < SP_TWO) begin
               fault      = 1'b1;
               fault_code = 2'd2;
            end else begin
               stack_we = 1'b1;
               wr_idx   = SPW'(sp - SP_TWO);
               sp_nxt   = sp - SP_ONE;
               if (op == 4'd3)      wr_val = a + b;
               else if (op == 4'd4) wr_val = a - b;
`ifdef STACK_CPU_MUL_EN
               else                 wr_val = a * b;
`endif
            end
         end
         4'd5: pc_nxt = pc + PC_ONE + k;
         4'd6: pc_nxt = pc + PC_ONE - k;
         4'd7, 4'd8, 4'd9, 4'd10: begin
            if (sp < SP_TWO) begin
               fault      = 1'b1;
               fault_code = 2'd2;
            end else begin
               sp_nxt = sp - SP_TWO;
               if (taken) pc_nxt = pc + PC_ONE + k;
            end
         end
         4'd11: halt = 1'b1;
         default: begin
            fault      = 1'b1;
            fault_code = 2'd3;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN: begin
            if (fault)     state_nxt = S_ERR;
            else if (halt) state_nxt = S_DONE;
         end
         default: if (start) state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= '0;
         sp       <= '0;
         icount   <= '0;
         result   <= '0;
         err_code <= '0;
      end else if (state != S_RUN) begin
         if (start) begin
            pc       <= '0;
            sp       <= '0;
            icount   <= '0;
            err_code <= '0;
         end
      end else if (fault) begin
         err_code <= fault_code;
      end else begin
         if (icount != 16'hFFFF) icount <= icount + 16'd1;
         if (halt) begin
            result <= (sp == '0) ? '0 : b;
         end else begin
            pc <= pc_nxt;
            sp <= sp_nxt;
         end
      end
   end

   // Memories carry no reset; program writes are locked out while running.
   always_ff @(posedge clk) begin
      if (prog_we && state != S_RUN) imem[prog_addr] <= prog_data;
      if (state == S_RUN && !fault && stack_we) stack[wr_idx] <= wr_val;
      if (state == S_RUN && !fault && var_we) vmem[k[VAR_AW-1:0]] <= b;
   end

endmodule

// File: tb/tb_stack_cpu.sv
// Bench for stack_cpu: table-driven programs, hand-written corner sequences and random programs vs a queue-based model.
module tb_stack_cpu;
   localparam int DW = 8;
   localparam int PW = 8;
   localparam int SD = 4;
   localparam int VA = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          prog_we = 1'b0;
   logic [PW-1:0] prog_addr = '0;
   logic [PW+3:0] prog_data = '0;
   logic          start = 1'b0;
   logic          busy, done, error;
   logic [1:0]    err_code;
   logic [DW-1:0] result;
   logic [15:0]   icount;

   stack_cpu #(.DATA_W(DW), .PC_W(PW), .STACK_DEPTH(SD), .VAR_AW(VA)) dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .busy(busy), .done(done),
      .error(error), .err_code(err_code), .result(result), .icount(icount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0][11:0] prog;
      logic             exp_err;
      logic [1:0]       exp_code;
      logic [7:0]       exp_res;
      logic [15:0]      exp_icnt;
      logic [7:0]       exp_cyc;
   } vec_t;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [11:0] mem_model [256];
   logic [11:0] pgm [$];
   int          mvars [16];
   int          mres = 0;
   vec_t        vecs [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [11:0] ins(input int op, input int k);
      ins = {k[7:0], op[3:0]};
   endfunction

   function automatic vec_t mkv(input logic [11:0] w0, w1, w2, w3, w4, w5, w6, w7,
                                input int e, input int c, input int r, input int n, input int y);
      vec_t v;
      v.prog     = {w7, w6, w5, w4, w3, w2, w1, w0};
      v.exp_err  = e[0];
      v.exp_code = c[1:0];
      v.exp_res  = r[7:0];
      v.exp_icnt = n[15:0];
      v.exp_cyc  = y[7:0];
      return v;
   endfunction

   task automatic load_pgm();
      foreach (pgm[i]) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = PW'(i);
         prog_data = pgm[i];
         mem_model[i] = pgm[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic run_prog(input string name, input int limit, output int cycles);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk({name, "_busy_on_start"}, 32'(busy), 1);
      chk({name, "_err_clr_on_start"}, 32'({error, err_code}), 0);
      cycles = 0;
      while (busy && cycles < limit) begin
         @(posedge clk);
         #1 cycles++;
      end
      chk({name, "_terminated"}, 32'(busy), 0);
   endtask

   // Reference: interprets mem_model directly with a queue stack and int variables.
   task automatic model_run(output int e_err, output int e_code, output int e_icnt, output int e_cyc);
      int st[$];
      int pc, cnt, op, k, a, b;
      bit fin, t;
      pc = 0; cnt = 0; fin = 0; e_err = 0; e_code = 0;
      for (int step = 0; step < 1000 && !fin; step++) begin
         op = int'(mem_model[pc][3:0]);
         k  = int'(mem_model[pc][11:4]);
         if (op == 0 || op == 1) begin
            if (st.size() == SD) begin e_err = 1; e_code = 1; fin = 1; end
            else begin st.push_back(op == 0 ? k : mvars[k % 16]); cnt++; pc = (pc + 1) % 256; end
         end else if (op == 2) begin
            if (st.size() < 1) begin e_err = 1; e_code = 2; fin = 1; end
            else begin mvars[k % 16] = st.pop_back(); cnt++; pc = (pc + 1) % 256; end
         end else if (op == 3 || op == 4 || op == 12) begin
`ifndef STACK_CPU_MUL_EN
            if (op == 12) begin e_err = 1; e_code = 3; fin = 1; end
            else
`endif
            if (st.size() < 2) begin e_err = 1; e_code = 2; fin = 1; end
            else begin
               b = st.pop_back(); a = st.pop_back();
               st.push_back(op == 3 ? (a + b) % 256 : op == 4 ? (a - b + 256) % 256 : (a * b) % 256);
               cnt++; pc = (pc + 1) % 256;
            end
         end else if (op == 5) begin
            cnt++; pc = (pc + 1 + k) % 256;
         end else if (op == 6) begin
            cnt++; pc = (pc + 1 - k + 256) % 256;
         end else if (op >= 7 && op <= 10) begin
            if (st.size() < 2) begin e_err = 1; e_code = 2; fin = 1; end
            else begin
               b = st.pop_back(); a = st.pop_back();
               t = (op == 7) ? (a == b) : (op == 8) ? (a != b) : (op == 9) ? (a <= b) : (a > b);
               cnt++; pc = (pc + 1 + (t ? k : 0)) % 256;
            end
         end else if (op == 11) begin
            mres = (st.size() == 0) ? 0 : st[st.size() - 1];
            cnt++; fin = 1;
         end else begin
            e_err = 1; e_code = 3; fin = 1;
         end
      end
      e_icnt = cnt;
      e_cyc  = e_err ? cnt + 1 : cnt;
   endtask

   initial begin
      logic [11:0] hl;
      int cyc, e_err, e_code, e_icnt, e_cyc, r, len;
      string nm;
      hl = ins(11, 0);

      vecs[0]  = mkv(ins(0,3), ins(0,4), ins(3,0), hl, hl, hl, hl, hl, 0, 0, 7, 4, 4);
      vecs[1]  = mkv(ins(0,2), ins(0,5), ins(4,0), hl, hl, hl, hl, hl, 0, 0, 8'hFD, 4, 4);
      vecs[2]  = mkv(ins(0,9), ins(2,1), ins(1,1), ins(1,1), ins(7,1), ins(0,0), ins(0,42), hl, 0, 0, 42, 7, 7);
      vecs[3]  = mkv(ins(3,0), hl, hl, hl, hl, hl, hl, hl, 1, 2, 0, 0, 1);
      vecs[4]  = mkv(ins(0,1), ins(0,1), ins(0,1), ins(0,1), ins(0,1), hl, hl, hl, 1, 1, 0, 4, 5);
`ifdef STACK_CPU_MUL_EN
      vecs[5]  = mkv(ins(0,6), ins(0,7), ins(12,0), hl, hl, hl, hl, hl, 0, 0, 42, 4, 4);
`else
      vecs[5]  = mkv(ins(0,6), ins(0,7), ins(12,0), hl, hl, hl, hl, hl, 1, 3, 0, 2, 3);
`endif
      vecs[6]  = mkv(hl, hl, hl, hl, hl, hl, hl, hl, 0, 0, 0, 1, 1);
      vecs[7]  = mkv(ins(0,1), ins(5,1), ins(0,5), ins(0,8), ins(3,0), hl, hl, hl, 0, 0, 9, 5, 5);
      vecs[8]  = mkv(ins(13,0), hl, hl, hl, hl, hl, hl, hl, 1, 3, 0, 0, 1);
      vecs[9]  = mkv(ins(0,5), ins(0,5), ins(10,1), ins(0,2), hl, hl, hl, hl, 0, 0, 2, 5, 5);
      vecs[10] = mkv(ins(0,3), ins(0,5), ins(9,1), ins(0,7), ins(0,1), hl, hl, hl, 0, 0, 1, 5, 5);
      vecs[11] = mkv(ins(0,4), ins(0,3), ins(8,1), ins(0,7), ins(0,9), hl, hl, hl, 0, 0, 9, 5, 5);
      vecs[12] = mkv(ins(2,0), hl, hl, hl, hl, hl, hl, hl, 1, 2, 0, 0, 1);
      vecs[13] = mkv(ins(0,2), ins(5,1), hl, ins(6,2), hl, hl, hl, hl, 0, 0, 2, 4, 4);

      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flags", 32'({done, error, err_code}), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_icount", 32'(icount), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         pgm.delete();
         for (int j = 0; j < 8; j++) pgm.push_back(vecs[i].prog[j]);
         load_pgm();
         nm = $sformatf("v%0d", i);
         run_prog(nm, 50, cyc);
         chk({nm, "_error"}, 32'(error), 32'(vecs[i].exp_err));
         chk({nm, "_done"}, 32'(done), 32'(!vecs[i].exp_err));
         chk({nm, "_err_code"}, 32'(err_code), 32'(vecs[i].exp_code));
         chk({nm, "_icount"}, 32'(icount), 32'(vecs[i].exp_icnt));
         chk({nm, "_cycles"}, cyc, 32'(vecs[i].exp_cyc));
         if (!vecs[i].exp_err) chk({nm, "_result"}, 32'(result), 32'(vecs[i].exp_res));
         if (i == 3 || i == 12) chk({nm, "_sp"}, 32'(dut.sp), 0);
         if (i == 4) begin
            chk("ovf_sp", 32'(dut.sp), 4);
            run_prog("ovf_rerun", 50, cyc);
            chk("ovf_rerun_code", 32'({error, err_code}), 32'({1'b1, 2'd1}));
            chk("ovf_rerun_icount", 32'(icount), 4);
         end
      end

      // prog_we while running must not alter instruction memory
      pgm.delete();
      for (int j = 0; j < 8; j++) pgm.push_back(vecs[0].prog[j]);
      load_pgm();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 8'd3; prog_data = ins(0, 99);
      @(negedge clk);
      prog_addr = 8'd2;
      @(negedge clk);
      prog_we = 1'b0;
      cyc = 0;
      while (busy && cyc < 50) begin @(posedge clk); #1 cyc++; end
      chk("we_run_result", 32'(result), 7);
      run_prog("we_rerun", 50, cyc);
      chk("we_rerun_result", 32'(result), 7);
      chk("we_rerun_icount", 32'(icount), 4);

      // asynchronous reset in the middle of a run
      run_prog("pre_rst", 50, cyc);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_flags", 32'({done, error, err_code}), 0);
      chk("arst_icount", 32'(icount), 0);
      chk("arst_result", 32'(result), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("arst_idle", 32'(busy), 0);

      // random phase: initialise every variable, then random forward-only programs
      mres = 0;
      pgm.delete();
      for (int v = 0; v < 16; v++) begin
         pgm.push_back(ins(0, int'($urandom_range(0, 255))));
         pgm.push_back(ins(2, v));
      end
      pgm.push_back(hl);
      load_pgm();
      model_run(e_err, e_code, e_icnt, e_cyc);
      run_prog("setup", 100, cyc);
      chk("setup_icount", 32'(icount), e_icnt);

      for (int t = 0; t < 40; t++) begin
         pgm.delete();
         len = int'($urandom_range(4, 12));
         for (int j = 0; j < len; j++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30)      pgm.push_back(ins(0, int'($urandom_range(0, 255))));
            else if (r < 40) pgm.push_back(ins(1, int'($urandom_range(0, 255))));
            else if (r < 48) pgm.push_back(ins(2, int'($urandom_range(0, 255))));
            else if (r < 58) pgm.push_back(ins(3, 0));
            else if (r < 66) pgm.push_back(ins(4, 0));
            else if (r < 70) pgm.push_back(ins(12, 0));
            else if (r < 74) pgm.push_back(ins(5, int'($urandom_range(0, 3))));
            else if (r < 76) pgm.push_back(ins(6, 0));
            else if (r < 92) pgm.push_back(ins(int'($urandom_range(7, 10)), int'($urandom_range(0, 3))));
            else if (r < 95) pgm.push_back(ins(int'($urandom_range(13, 15)), 0));
            else             pgm.push_back(hl);
         end
         for (int j = 0; j < 5; j++) pgm.push_back(hl);
         load_pgm();
         model_run(e_err, e_code, e_icnt, e_cyc);
         nm = $sformatf("rnd%0d", t);
         run_prog(nm, 300, cyc);
         chk({nm, "_state"}, 32'({done, error}), 32'({e_err == 0, e_err != 0}));
         chk({nm, "_err_code"}, 32'(err_code), e_code);
         chk({nm, "_icount"}, 32'(icount), e_icnt);
         chk({nm, "_cycles"}, cyc, e_cyc);
         chk({nm, "_result"}, 32'(result), mres);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
